change_dispenser: RTL and testbench
===================================

# change_dispenser

Output-side counterpart of the coin-credit transition logic. It takes the registered credit state (0–8, in 5-cent units) once per accepted coin. When credit reaches the price it issues a one-cycle vend pulse. It then pays back any overpayment as a sequence of dime/nickel requests to the coin hopper over a 4-phase req/ack handshake. While busy it tells upstream to stop accepting coins. A hopper that stops responding drives it into a sticky fault.

## Interface
Parameters:
- PRICE_UNITS, 4, item price in 5-cent units; credit ≥ PRICE_UNITS triggers a vend
- TIMEOUT, 16, max cycles coin_req may stay high without coin_ack before fault (≥2)

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- state  input  4  credit state from transition logic; valid values 0–8
- state_valid  input  1  one-cycle strobe: state holds a newly latched credit value
- busy  output  1  high while vending, dispensing or faulted; upstream must hold coins off
- vend  output  1  one-cycle pulse: release item
- coin_req  output  1  request hopper to drop one coin
- coin_type  output  2  coin code for the request, same encoding as coin inputs: 01 nickel, 10 dime; 00 when no request
- coin_ack  input  1  hopper acknowledge (4-phase)
- change_left  output  3  remaining change in 5-cent units
- fault  output  1  sticky hopper-timeout flag

## Operation
- Reset (async assert, sync release) values:
  - state = IDLE
  - busy=0, vend=0, coin_req=0, coin_type=00
  - change_left=0, fault=0, timeout counter=0
- IDLE: busy=0.
  - On state_valid with PRICE_UNITS ≤ state ≤ 8: latch change_left = state − PRICE_UNITS and go to VEND.
  - state_valid with state < PRICE_UNITS or state > 8: ignored, no output change.
- VEND: busy=1, vend=1 for exactly this cycle.
  - change_left==0 → IDLE.
  - Otherwise → REQ.
- REQ: coin_req=1.
  - coin_type = 10 if change_left ≥ 2, else 01. Held stable for the whole request.
  - On coin_ack sampled high: change_left −= 2 (dime) or 1 (nickel), clear the counter, go to RELEASE.
  - Otherwise increment the timeout counter. Reaching TIMEOUT → FAULT.
- RELEASE: coin_req=0, coin_type=00.
  - Wait until coin_ack is sampled low.
  - Then change_left==0 → IDLE, else → REQ.
  - No timeout in this state.
- FAULT: busy=1, fault=1, coin_req=0, coin_type=00. change_left frozen. Exit only via reset_n.
- state_valid while busy=1 is ignored. Upstream guarantees none arrive, but the block must not re-latch.
- Coin sequence is greedy: dimes first, then at most one nickel.
  - 1 → N
  - 2 → D
  - 3 → D, N
  - 4 → D, D
- Arithmetic: change_left is 3 bits (max 4). The subtraction can never underflow because a dime is only issued when change_left ≥ 2.

## Timing
- state_valid at edge N → vend=1 and busy=1 during cycle N+1. coin_req rises at edge N+2 at the earliest.
- Zero change: busy drops at edge N+2. Total occupancy is 1 cycle.
- coin_ack high sampled at edge M:
  - coin_req low and change_left updated from edge M+1.
- coin_ack low sampled at edge K:
  - coin_req high again (if change remains) or busy low from edge K+1.
- If coin_ack is already high on the cycle coin_req rises, it is accepted at the next edge. Minimum REQ dwell is 1 cycle.
- Timeout: coin_req high for TIMEOUT consecutive edges without ack → FAULT from the following edge.
- An ack arriving on the same edge the counter would expire wins: the coin is counted and no fault is raised.
- reset_n asserted mid-dispense: all outputs go to reset values immediately (asynchronously). Undispensed change is discarded.

## Test plan
- Reset, then state_valid with state=2 → no vend, busy stays 0, change_left=0.
- state=4 → vend pulse 1 cycle, busy high for exactly 1 cycle, no coin_req.
- state=7, hopper acks after 3 cycles and releases 2 cycles later:
  - vend, then coin_type 10 → 01.
  - change_left 3→1→0.
  - busy low after the second release.
- state=8, hopper holds ack high across the coin_req rise → first dime accepted 1 cycle after the request. Second dime only after ack drops. Two requests total.
- state=5 with ack never asserted:
  - coin_req=1, coin_type=01 for TIMEOUT cycles, then fault=1, busy=1, coin_req=0.
  - Later acks and state_valid are ignored. reset_n clears everything.
- state=6 with reset_n pulsed low mid-REQ → coin_req, busy, change_left drop to 0 asynchronously. Next state_valid=4 vends normally.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: credit strobe, status and hopper req/ack handshake bundle
interface change_dispenser_if;
    logic [3:0] state;
    logic       state_valid;
    logic       busy;
    logic       vend;
    logic       coin_req;
    logic [1:0] coin_type;
    logic       coin_ack;
    logic [2:0] change_left;
    logic       fault;
    modport master (
        output state, state_valid, coin_ack,
        input  busy, vend, coin_req, coin_type, change_left, fault
    );
    modport slave (
        input  state, state_valid, coin_ack,
        output busy, vend, coin_req, coin_type, change_left, fault
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: vends on sufficient credit, then pays change greedily over a 4-phase hopper handshake
module change_dispenser #(
    parameter int PRICE_UNITS = 4,
    parameter int TIMEOUT     = 16
) (
    input logic               clk,
    input logic               reset_n,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VEND, REQ, RELEASE, FAULT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t          st_q, st_d;
    logic [2:0]      cl_q, cl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            credit_ok;
    assign credit_ok = bus.state >= 4'(PRICE_UNITS) && bus.state <= 4'd8;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= IDLE;
            cl_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cl_q  <= cl_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        st_d  = st_q;
        cl_d  = cl_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: if (bus.state_valid && credit_ok) begin
                cl_d = 3'(bus.state - 4'(PRICE_UNITS));
                st_d = VEND;
            end
            VEND: st_d = cl_q == 3'd0 ? IDLE : REQ;
            // an ack on the expiring edge still counts the coin
            REQ: if (bus.coin_ack) begin
                cl_d  = cl_q - (cl_q >= 3'd2 ? 3'd2 : 3'd1);
                cnt_d = '0;
                st_d  = RELEASE;
            end else begin
                cnt_d = cnt_q + 1'b1;
                st_d  = cnt_d == CW'(TIMEOUT) ? FAULT : REQ;
            end
            RELEASE: if (!bus.coin_ack) st_d = cl_q == 3'd0 ? IDLE : REQ;
            default: ;
        endcase
    end
    assign bus.busy        = st_q != IDLE;
    assign bus.vend        = st_q == VEND;
    assign bus.coin_req    = st_q == REQ;
    assign bus.coin_type   = st_q == REQ ? (cl_q >= 3'd2 ? 2'b10 : 2'b01) : 2'b00;
    assign bus.change_left = cl_q;
    assign bus.fault       = st_q == FAULT;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, random transactions vs. a greedy-change model, and handshake/fault corner cases
module tb_change_dispenser;
    localparam int TO = 16;
    logic clk = 0;
    logic reset_n = 0;
    change_dispenser_if bus();
    change_dispenser #(.PRICE_UNITS(4), .TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [1:0] obs_coin[4];
    int obs_cl[4];
    int obs_len[4];
    int obs_n, obs_vend, obs_busy;
    bit obs_to;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [3:0] s, input int ad, input int rd);
        int wait_n, rel_n;
        logic prev_req;
        for (int i = 0; i < 4; i++) begin
            obs_coin[i] = 0; obs_cl[i] = 0; obs_len[i] = 0;
        end
        obs_n = 0; obs_vend = 0; obs_busy = 0; obs_to = 1;
        wait_n = 0; rel_n = 0; prev_req = 0;
        @(negedge clk); bus.state = s; bus.state_valid = 1;
        @(negedge clk); bus.state_valid = 0; bus.state = 0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            obs_vend += int'(bus.vend);
            obs_busy += int'(bus.busy);
            if (bus.coin_req && !prev_req && obs_n < 4) obs_coin[obs_n] = bus.coin_type;
            if (bus.coin_req && obs_n < 4) obs_len[obs_n]++;
            if (!bus.coin_req && prev_req) begin
                if (obs_n < 4) obs_cl[obs_n] = int'(bus.change_left);
                obs_n++;
            end
            if (bus.coin_req && !bus.coin_ack) begin
                wait_n++;
                if (wait_n > ad) begin bus.coin_ack = 1; wait_n = 0; end
            end else if (!bus.coin_req && bus.coin_ack) begin
                rel_n++;
                if (rel_n > rd) begin bus.coin_ack = 0; rel_n = 0; end
            end
            prev_req = bus.coin_req;
            if (!bus.busy) begin obs_to = 0; break; end
        end
    endtask

    typedef struct {
        logic [3:0] st;
        int vends;
        int ncoin;
        logic [1:0] c0;
        logic [1:0] c1;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int n, bad_type, chg, d, k, rem, ad;
        logic [3:0] s;
        tbl[0]  = '{4'd0,  0, 0, 2'b00, 2'b00};
        tbl[1]  = '{4'd2,  0, 0, 2'b00, 2'b00};
        tbl[2]  = '{4'd3,  0, 0, 2'b00, 2'b00};
        tbl[3]  = '{4'd4,  1, 0, 2'b00, 2'b00};
        tbl[4]  = '{4'd5,  1, 1, 2'b01, 2'b00};
        tbl[5]  = '{4'd6,  1, 1, 2'b10, 2'b00};
        tbl[6]  = '{4'd7,  1, 2, 2'b10, 2'b01};
        tbl[7]  = '{4'd8,  1, 2, 2'b10, 2'b10};
        tbl[8]  = '{4'd9,  0, 0, 2'b00, 2'b00};
        tbl[9]  = '{4'd15, 0, 0, 2'b00, 2'b00};
        tbl[10] = '{4'd1,  0, 0, 2'b00, 2'b00};
        bus.state = 0; bus.state_valid = 0; bus.coin_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_vend", int'(bus.vend), 0);
        chk("rst_req", int'(bus.coin_req), 0);
        chk("rst_type", int'(bus.coin_type), 0);
        chk("rst_cl", int'(bus.change_left), 0);
        chk("rst_fault", int'(bus.fault), 0);
        reset_n = 1;

        foreach (tbl[i]) begin
            run_txn(tbl[i].st, 1, 1);
            chk($sformatf("tbl%0d_done", i), int'(obs_to), 0);
            chk($sformatf("tbl%0d_vend", i), obs_vend, tbl[i].vends);
            chk($sformatf("tbl%0d_ncoin", i), obs_n, tbl[i].ncoin);
            chk($sformatf("tbl%0d_c0", i), int'(obs_coin[0]), int'(tbl[i].c0));
            chk($sformatf("tbl%0d_c1", i), int'(obs_coin[1]), int'(tbl[i].c1));
            chk($sformatf("tbl%0d_cl", i), int'(bus.change_left), 0);
        end
        run_txn(4'd4, 0, 0);
        chk("s4_busy_cycles", obs_busy, 1);

        for (int t = 0; t < 40; t++) begin
            s = 4'($urandom_range(0, 15));
            ad = int'($urandom_range(0, 5));
            run_txn(s, ad, int'($urandom_range(0, 3)));
            chg = (s >= 4 && s <= 8) ? int'(s) - 4 : 0;
            d = chg / 2;
            chk($sformatf("rnd%0d_done", t), int'(obs_to), 0);
            chk($sformatf("rnd%0d_vend", t), obs_vend, (s >= 4 && s <= 8) ? 1 : 0);
            chk($sformatf("rnd%0d_ncoin", t), obs_n, d + chg % 2);
            rem = chg;
            for (k = 0; k < d + chg % 2 && k < 4; k++) begin
                rem -= (k < d) ? 2 : 1;
                chk($sformatf("rnd%0d_coin%0d", t, k), int'(obs_coin[k]), (k < d) ? 2 : 1);
                chk($sformatf("rnd%0d_cl%0d", t, k), obs_cl[k], rem);
                chk($sformatf("rnd%0d_len%0d", t, k), obs_len[k], ad + 1);
            end
            if (chg == 0) chk($sformatf("rnd%0d_busy", t), obs_busy, (s >= 4 && s <= 8) ? 1 : 0);
        end

        run_txn(4'd7, 3, 2);
        chk("s7_vend", obs_vend, 1);
        chk("s7_ncoin", obs_n, 2);
        chk("s7_c0", int'(obs_coin[0]), 2);
        chk("s7_c1", int'(obs_coin[1]), 1);
        chk("s7_cl0", obs_cl[0], 1);
        chk("s7_cl1", obs_cl[1], 0);
        chk("s7_len0", obs_len[0], 4);
        chk("s7_busy_end", int'(bus.busy), 0);

        bus.coin_ack = 1;
        @(negedge clk); bus.state = 8; bus.state_valid = 1;
        @(negedge clk); bus.state_valid = 0;
        chk("s8_vend", int'(bus.vend), 1);
        @(negedge clk);
        chk("s8_req1", int'(bus.coin_req), 1);
        chk("s8_type1", int'(bus.coin_type), 2);
        @(negedge clk);
        chk("s8_req1_drop", int'(bus.coin_req), 0);
        chk("s8_cl1", int'(bus.change_left), 2);
        n = 0;
        repeat (3) begin @(negedge clk); n += int'(bus.coin_req); end
        chk("s8_hold_no_req", n, 0);
        bus.coin_ack = 0;
        @(negedge clk);
        chk("s8_req2", int'(bus.coin_req), 1);
        chk("s8_type2", int'(bus.coin_type), 2);
        bus.coin_ack = 1;
        @(negedge clk);
        chk("s8_cl2", int'(bus.change_left), 0);
        chk("s8_req2_drop", int'(bus.coin_req), 0);
        bus.coin_ack = 0;
        @(negedge clk);
        chk("s8_busy_end", int'(bus.busy), 0);

        @(negedge clk); bus.state = 5; bus.state_valid = 1;
        @(negedge clk); bus.state_valid = 0;
        chk("to_vend", int'(bus.vend), 1);
        n = 0; bad_type = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.coin_req) break;
            if (bus.coin_type != 2'b01) bad_type++;
            n++;
        end
        chk("to_req_cycles", n, TO);
        chk("to_type", bad_type, 0);
        chk("to_fault", int'(bus.fault), 1);
        chk("to_busy", int'(bus.busy), 1);
        chk("to_cl", int'(bus.change_left), 1);
        bus.coin_ack = 1; bus.state = 4; bus.state_valid = 1;
        @(negedge clk); bus.state_valid = 0;
        @(negedge clk);
        chk("to_sticky_fault", int'(bus.fault), 1);
        chk("to_no_vend", int'(bus.vend), 0);
        chk("to_no_req", int'(bus.coin_req), 0);
        chk("to_cl_frozen", int'(bus.change_left), 1);
        bus.coin_ack = 0;
        #2 reset_n = 0;
        #1;
        chk("to_rst_fault", int'(bus.fault), 0);
        chk("to_rst_busy", int'(bus.busy), 0);
        @(negedge clk); reset_n = 1;

        @(negedge clk); bus.state = 6; bus.state_valid = 1;
        @(negedge clk); bus.state_valid = 0;
        @(negedge clk);
        chk("ar_req_before", int'(bus.coin_req), 1);
        #2 reset_n = 0;
        #1;
        chk("ar_req", int'(bus.coin_req), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_cl", int'(bus.change_left), 0);
        @(negedge clk); reset_n = 1;
        run_txn(4'd4, 0, 0);
        chk("ar_next_vend", obs_vend, 1);
        chk("ar_next_busy", obs_busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
